// File: rtl/shared_buffer_list_ctrl.sv
// Per-VC linked-list manager threading FIFO address lists through a shared flit bank.
// Optional macro SHARED_BUF_RESERVE_EN keeps one slot per empty VC out of reach of busy VCs.
module shared_buffer_list_ctrl #(
  parameter int unsigned NUM_VCS           = 4,
  parameter int unsigned MEMORY_BANK_DEPTH = 32
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             push_valid,
  input  logic [$clog2(NUM_VCS)-1:0]                       push_vc,
  output logic                                             push_ready,
  output logic [$clog2(MEMORY_BANK_DEPTH)-1:0]             push_addr,
  input  logic                                             pop_valid,
  input  logic [$clog2(NUM_VCS)-1:0]                       pop_vc,
  output logic [$clog2(MEMORY_BANK_DEPTH)-1:0]             pop_addr,
  input  logic [$clog2(MEMORY_BANK_DEPTH)-1:0]             available_flit_addr,
  input  logic                                             tracker_empty,
  output logic                                             allocate_addr,
  output logic [$clog2(MEMORY_BANK_DEPTH)-1:0]             freed_flit_addr,
  output logic                                             reclaim_addr,
  output logic [NUM_VCS-1:0]                               vc_empty,
  output logic [NUM_VCS*$clog2(MEMORY_BANK_DEPTH+1)-1:0]   vc_count,
  output logic                                             pop_underflow
);

  localparam int unsigned VC_IDX_W = $clog2(NUM_VCS);
  localparam int unsigned ADDR_W   = $clog2(MEMORY_BANK_DEPTH);
  localparam int unsigned CNT_W    = $clog2(MEMORY_BANK_DEPTH + 1);

  logic [ADDR_W-1:0] r_head     [NUM_VCS];
  logic [ADDR_W-1:0] r_tail     [NUM_VCS];
  logic [CNT_W-1:0]  r_count    [NUM_VCS];
  logic [ADDR_W-1:0] r_next_ptr [MEMORY_BANK_DEPTH];
  logic [CNT_W-1:0]  r_total_count;
  logic [NUM_VCS-1:0] r_vc_empty;
  logic              r_pop_underflow;

  logic [CNT_W-1:0]  w_count_nxt [NUM_VCS];
  logic [CNT_W-1:0]  w_pop_cnt;
  logic [CNT_W-1:0]  w_push_cnt;
  logic              w_pop_fire;
  logic              w_push_fire;
  logic              w_push_ready;
  logic              w_push_to_head;

  assign w_pop_cnt  = r_count[pop_vc];
  assign w_push_cnt = r_count[push_vc];
  assign w_pop_fire = pop_valid & (w_pop_cnt != '0);

`ifdef SHARED_BUF_RESERVE_EN
  logic [CNT_W-1:0] w_reserved;
  logic [CNT_W-1:0] w_free;

  // Count idle VCs (other than the target) that still need a guaranteed slot.
  always_comb begin
    w_reserved = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if ((VC_IDX_W'(v) != push_vc) && (r_count[v] == '0)) begin
        w_reserved = w_reserved + CNT_W'(1);
      end
    end
  end

  assign w_free       = CNT_W'(MEMORY_BANK_DEPTH) - r_total_count + CNT_W'(w_pop_fire);
  assign w_push_ready = (~tracker_empty | w_pop_fire) &
                        ((w_push_cnt == '0) | (w_free > w_reserved));
`else
  // An empty tracker bypasses the slot being freed this cycle straight to the push.
  assign w_push_ready = ~tracker_empty | w_pop_fire;
`endif

  assign w_push_fire    = push_valid & w_push_ready;
  assign w_push_to_head = (w_push_cnt == '0) |
                          ((w_push_cnt == CNT_W'(1)) & w_pop_fire & (pop_vc == push_vc));

  assign push_ready      = w_push_ready;
  assign push_addr       = available_flit_addr;
  assign allocate_addr   = w_push_fire;
  assign pop_addr        = r_head[pop_vc];
  assign freed_flit_addr = r_head[pop_vc];
  assign reclaim_addr    = w_pop_fire;
  assign vc_empty        = r_vc_empty;
  assign pop_underflow   = r_pop_underflow;

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      w_count_nxt[v] = r_count[v];
      if (w_push_fire && (push_vc == VC_IDX_W'(v))) w_count_nxt[v] = w_count_nxt[v] + CNT_W'(1);
      if (w_pop_fire && (pop_vc == VC_IDX_W'(v)))   w_count_nxt[v] = w_count_nxt[v] - CNT_W'(1);
    end
  end

  // VC0 occupies the most significant field.
  always_comb begin
    vc_count = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      vc_count[(NUM_VCS-1-v)*CNT_W +: CNT_W] = r_count[v];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        r_head[v]  <= '0;
        r_tail[v]  <= '0;
        r_count[v] <= '0;
      end
      r_total_count   <= '0;
      r_vc_empty      <= '1;
      r_pop_underflow <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        r_count[v]    <= w_count_nxt[v];
        r_vc_empty[v] <= (w_count_nxt[v] == '0);
      end
      r_total_count   <= r_total_count + CNT_W'(w_push_fire) - CNT_W'(w_pop_fire);
      r_pop_underflow <= pop_valid & ~w_pop_fire;
      if (w_pop_fire && (w_pop_cnt > CNT_W'(1))) begin
        r_head[pop_vc] <= r_next_ptr[r_head[pop_vc]];
      end
      // Push into an empty (or draining-to-empty) list overrides the pop's head advance.
      if (w_push_fire) begin
        r_tail[push_vc] <= available_flit_addr;
        if (w_push_to_head) r_head[push_vc] <= available_flit_addr;
      end
    end
  end

  // Link storage holds no meaningful value after reset, so it is left unreset.
  always_ff @(posedge clk) begin
    if (!reset && w_push_fire && !w_push_to_head) begin
      r_next_ptr[r_tail[push_vc]] <= available_flit_addr;
    end
  end

endmodule
